// File: rtl/pack_arb_pkg.sv
// Shared types and helpers for the two-requester bit-pair packing arbiter.
package pack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int CNT_W = 4;

  // Swapped order puts c in the MSB; the default order puts d in the MSB.
  function automatic logic [1:0] pack_pair(input logic c, input logic d, input logic swap);
    logic [1:0] pair;
    if (swap) begin
      pair = {c, d};
    end else begin
      pair = {d, c};
    end
    return pair;
  endfunction

endpackage

// File: rtl/pack_reg.sv
// Output holding register: loads an accepted pair, holds it under backpressure
// and drops it once the consumer takes it.
module pack_reg
  import pack_arb_pkg::*;
#(
  parameter bit SWAP1 = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       owner_i,
  input  logic       c_i,
  input  logic       d_i,
  input  logic       out_ready_i,
  output logic [1:0] out_b_o,
  output logic       out_x_o,
  output logic       out_owner_o,
  output logic       out_valid_o
);

  logic [1:0] b_q, b_d;
  logic       x_q, x_d;
  logic       owner_q, owner_d;
  logic       valid_q, valid_d;

  // Next-state for the held pair: a load wins over a consume.
  always_comb begin
    b_d     = b_q;
    x_d     = x_q;
    owner_d = owner_q;
    valid_d = valid_q;
    if (load_i) begin
      b_d     = pack_pair(c_i, d_i, owner_i & SWAP1);
      x_d     = ~d_i;
      owner_d = owner_i;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register bank for the held pair.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_q     <= 2'b00;
      x_q     <= 1'b0;
      owner_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      b_q     <= b_d;
      x_q     <= x_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

  assign out_b_o     = b_q;
  assign out_x_o     = x_q;
  assign out_owner_o = owner_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/pack_arb.sv
// Two-requester burst-limited arbiter feeding a single packed-pair output register.
module pack_arb
  import pack_arb_pkg::*;
#(
  parameter bit          SWAP1     = 1'b1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req0_c,
  input  logic       req0_d,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_c,
  input  logic       req1_d,
  output logic       req1_ready,
  output logic [1:0] out_b,
  output logic       out_x,
  output logic       out_owner,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             room_s, stall_s, limit_s, xfer_s;

  assign room_s  = !out_valid || out_ready;
  assign stall_s = out_valid && !out_ready;
  assign limit_s = (cnt_q == MAX_CNT);
  assign xfer_s  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Grant/next-state logic. Ready is withheld once the burst limit is reached
  // and the other side waits, so the switching cycle carries no transfer.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_q)) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        req0_ready = room_s && !(limit_s && req1_valid);
        if (req0_valid && stall_s) begin
          state_d = OWN0;
        end else if (req1_valid && (limit_s || !req0_valid)) begin
          state_d = OWN1;
        end else if (!req0_valid && !req1_valid) begin
          state_d = IDLE;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        req1_ready = room_s && !(limit_s && req0_valid);
        if (req1_valid && stall_s) begin
          state_d = OWN1;
        end else if (req0_valid && (limit_s || !req1_valid)) begin
          state_d = OWN0;
        end else if (!req0_valid && !req1_valid) begin
          state_d = IDLE;
        end else begin
          state_d = OWN1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst counter and last-owner bookkeeping; counter saturates at the limit.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (xfer_s && !limit_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (state_d == OWN0 && state_q != OWN0) begin
      last_d = 1'b0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

  pack_reg #(
    .SWAP1(SWAP1)
  ) u_pack_reg (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_i      (xfer_s),
    .owner_i     (req1_ready),
    .c_i         (req1_ready ? req1_c : req0_c),
    .d_i         (req1_ready ? req1_d : req0_d),
    .out_ready_i (out_ready),
    .out_b_o     (out_b),
    .out_x_o     (out_x),
    .out_owner_o (out_owner),
    .out_valid_o (out_valid)
  );

endmodule

// File: tb/tb_pack_arb.sv
// Directed self-checking bench for pack_arb (SWAP1=1 and SWAP1=0 instances).
module tb_pack_arb;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_c, req0_d;
  logic       req1_valid, req1_c, req1_d;
  logic       out_ready;
  logic       req0_ready, req1_ready;
  logic [1:0] out_b;
  logic       out_x, out_owner, out_valid, busy;
  logic       b_req0_ready, b_req1_ready;
  logic [1:0] b_out_b;
  logic       b_out_x, b_out_owner, b_out_valid, b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] burst_exp [11];

  always #5 clock = ~clock;

  pack_arb #(.SWAP1(1'b1), .MAX_BURST(4)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_c(req0_c), .req0_d(req0_d), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_c(req1_c), .req1_d(req1_d), .req1_ready(req1_ready),
    .out_b(out_b), .out_x(out_x), .out_owner(out_owner), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  pack_arb #(.SWAP1(1'b0), .MAX_BURST(4)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_c(req0_c), .req0_d(req0_d), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_c(req1_c), .req1_d(req1_d), .req1_ready(b_req1_ready),
    .out_b(b_out_b), .out_x(b_out_x), .out_owner(b_out_owner), .out_valid(b_out_valid),
    .out_ready(out_ready), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_c = 1'b0; req0_d = 1'b0;
    req1_valid = 1'b0; req1_c = 1'b0; req1_d = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                  2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10};

    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_c = 1'b0; req0_d = 1'b0;
    req1_valid = 1'b0; req1_c = 1'b0; req1_d = 1'b0;
    out_ready  = 1'b1;
    #12;
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_b", 8'(out_b), 8'd0);
    chk("rst_x", 8'(out_x), 8'd0);
    chk("rst_owner", 8'(out_owner), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rdy", 8'({req0_ready, req1_ready}), 8'd0);

    // Single req0 pair {c=0,d=1}
    tick();
    reset_n = 1'b1;
    req0_valid = 1'b1; req0_c = 1'b0; req0_d = 1'b1;
    tick();
    chk("grant0_busy", 8'(busy), 8'd1);
    chk("grant0_rdy", 8'(req0_ready), 8'd1);
    tick();
    chk("single_valid", 8'(out_valid), 8'd1);
    chk("single_b", 8'(out_b), 8'h2);
    chk("single_x", 8'(out_x), 8'd0);
    chk("single_owner", 8'(out_owner), 8'd0);
    req0_valid = 1'b0;
    tick();
    chk("drain_valid", 8'(out_valid), 8'd0);
    chk("drain_busy", 8'(busy), 8'd0);

    // Both valid from reset: bursts of 4 with one switch cycle between groups
    apply_reset();
    req0_valid = 1'b1; req0_c = 1'b1; req0_d = 1'b0;
    req1_valid = 1'b1; req1_c = 1'b0; req1_d = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("burst_vo%0d", i), 8'({out_valid, out_owner}), 8'(burst_exp[i]));
      chk("excl", 8'(req0_ready & req1_ready), 8'd0);
      if (i == 0) chk("burst_b0", 8'(out_b), 8'h1);
    end

    // Swap ordering: req1 {c=0,d=1}
    apply_reset();
    req1_valid = 1'b1; req1_c = 1'b0; req1_d = 1'b1;
    tick();
    tick();
    chk("swap1_b", 8'(out_b), 8'h1);
    chk("swap0_b", 8'(b_out_b), 8'h2);
    chk("swap_owner", 8'(out_owner), 8'd1);
    chk("swap_x", 8'(out_x), 8'd0);

    // Backpressure hold: out_ready low for 5 cycles
    apply_reset();
    out_ready  = 1'b0;
    req0_valid = 1'b1; req0_c = 1'b1; req0_d = 1'b0;
    tick();
    chk("stall_rdy0", 8'(req0_ready), 8'd1);
    tick();
    chk("stall_b0", 8'(out_b), 8'h1);
    chk("stall_cnt0", 8'(dut_a.cnt_q), 8'd1);
    req0_c = 1'b0; req0_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_b", 8'(out_b), 8'h1);
      chk("stall_rdy", 8'(req0_ready), 8'd0);
      chk("stall_cnt", 8'(dut_a.cnt_q), 8'd1);
      chk("stall_busy", 8'({busy, out_valid}), 8'h3);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_rdy", 8'(req0_ready), 8'd1);
    tick();
    chk("unstall_b", 8'(out_b), 8'h2);
    chk("unstall_cnt", 8'(dut_a.cnt_q), 8'd2);

    // Asynchronous reset mid-burst
    req1_valid = 1'b1; req1_c = 1'b1; req1_d = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(out_valid), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_rdy", 8'({req0_ready, req1_ready}), 8'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("tie_busy", 8'(busy), 8'd1);
    chk("tie_rdy", 8'({req0_ready, req1_ready}), 8'h2);
    chk("tie_novalid", 8'(out_valid), 8'd0);

    // Owner 0 drops valid at counter 2 while req1 waits
    tick();
    tick();
    chk("drop_cnt", 8'(dut_a.cnt_q), 8'd2);
    req0_valid = 1'b0;
    tick();
    chk("drop_rdy", 8'({req0_ready, req1_ready}), 8'h1);
    chk("drop_cnt_clr", 8'(dut_a.cnt_q), 8'd0);
    tick();
    chk("drop_out", 8'({out_valid, out_owner}), 8'h3);
    chk("drop_b", 8'(out_b), 8'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pack_arb.md
PACK_ARB -- requirements
Module: pack_arb

Interface
REQ-001 SHALL have parameter SWAP1, default 1: when 1, requester 1 packs as {c,d} and requester 0 as {d,c}; when 0, both pack as {d,c}.
REQ-002 SHALL have parameter MAX_BURST, default 4, legal range 1..15: maximum consecutive transfers granted to one owner while the other requester waits.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a bit pair.
- req0_c, req0_d  in  1 each  requester 0 payload.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid, req1_c, req1_d, req1_ready  same roles for requester 1.
- out_b  out  2  packed pair.
- out_x  out  1  ~d of the accepted pair.
- out_owner  out  1  requester index of the held pair.
- out_valid  out  1  output register holds a pair.
- out_ready  in  1  downstream consumes the pair.
- busy  out  1  FSM not in IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, OWN0 and OWN1, with busy = (state != IDLE).
REQ-005 SHALL drive reqN_ready = (state == OWNn) && (!out_valid || out_ready), combinationally.
REQ-006 SHALL transfer on reqN_valid && reqN_ready and load the pair on the next edge, giving 1-cycle latency:
- out_b = {d,c} for requester 0.
- out_b = SWAP1 ? {c,d} : {d,c} for requester 1.
- out_x = ~d.
- out_owner = N.
- out_valid = 1.
REQ-007 SHALL clear out_valid on out_valid && out_ready with no new transfer; a simultaneous consume and transfer SHALL reload the register with out_valid staying 1.
REQ-008 SHALL hold out_b, out_x and out_owner stable while out_valid && !out_ready.
REQ-009 SHALL transition from IDLE as follows:
- Only req0_valid: go to OWN0.
- Only req1_valid: go to OWN1.
- Both valid: go to the requester that is not last_owner.
- Neither valid: stay in IDLE.
REQ-010 SHALL increment a 4-bit burst counter on each transfer in OWNn and clear it on any state change.
REQ-011 SHALL transition from OWNn as follows:
- The other requester is valid and (counter == MAX_BURST, or reqN_valid == 0): go to the other OWN state.
- Neither requester is valid: go to IDLE.
- Otherwise: stay.
REQ-012 SHALL update last_owner to n on every entry to OWNn.
REQ-013 SHALL make the grant take effect in the cycle after the transition, with no transfer in the switching cycle counted against the new owner.
REQ-014 SHALL, with MAX_BURST = 1 and both requesters continuously valid, alternate owners after every transfer.
REQ-015 SHALL never issue ready to both requesters in the same cycle.
REQ-016 SHALL keep the grant while out_ready = 0, without switching owner or incrementing the counter, until a transfer occurs or the owner drops valid.

Reset
REQ-017 SHALL, on reset_n low and independent of clock, force:
- state = IDLE.
- last_owner = 1, so requester 0 wins the first tie.
- burst counter = 0.
- out_valid = 0, out_b = 2'b00, out_x = 0, out_owner = 0.
- busy = 0; req0_ready = req1_ready = 0.
REQ-018 SHALL drop an in-flight held pair when reset is asserted mid-operation, with no output after reset release until a new transfer.
REQ-019 SHALL resume normal behaviour on the first rising edge after reset_n deasserts.

Structure
REQ-020 SHALL place the FSM state encoding (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2) and the burst counter width in a shared package, pack_arb_pkg.
REQ-021 SHALL implement the output register as one sub-module, pack_reg (load, hold and consume handling, plus the swap mux), with the arbiter FSM in pack_arb.

Verification
REQ-022 The bench SHALL cover:
- Reset, then req0 = {c=0,d=1} valid alone -> one cycle later out_b = 2'b10, out_x = 0, out_owner = 0.
- Both valid from reset with MAX_BURST = 4 and out_ready = 1 -> owners 0,0,0,0,1,1,1,1,0, with one switch cycle between each group.
- req1 = {c=0,d=1} with SWAP1 = 1 -> out_b = 2'b01; with SWAP1 = 0 -> out_b = 2'b10.
- out_ready = 0 for 5 cycles while req0 is valid -> out_b held; req0_ready = 0 after the first transfer; the counter does not advance.
- reset_n pulsed low mid-burst with out_valid = 1 -> out_valid = 0 and state IDLE immediately; the first tie after release goes to requester 0.
- Owner 0 drops valid with req1 valid and counter = 2 -> switch to OWN1 the next cycle.
